multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 19-bit core datapath. Decodes Instr[3:0] and drives the
//  datapath control strobes: ResultSrc, PcSrc, RegWrite, ImmSrc, L and ALUControl.
//  Adds a PC-enable and req/ack handshakes to instruction and data memory, so slow
//  memories stall the core instead of corrupting state. Sits beside the datapath in the core top.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for any ack; on expiry -> HALT with bus_err=1
//  TW           5   timeout counter width; must satisfy 2**TW > MEM_TIMEOUT
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-LOW reset (0 = in reset)
//  run         in   1   level; leaving IDLE requires run=1; sampled only in IDLE and FETCH entry
//  Instr       in   19  instruction from imem; opcode = Instr[3:0]; must be stable from imem_ack until WB exits
//  Zero        in   1   ALU zero flag from datapath; sampled in EXEC
//  imem_req    out  1   instruction fetch request; held until imem_ack
//  imem_ack    in   1   fetch complete; Instr valid this cycle
//  dmem_req    out  1   data access request; held until dmem_ack
//  dmem_we     out  1   1 = store; valid while dmem_req=1
//  dmem_ack    in   1   data access complete; ReadData valid this cycle for loads
//  pc_en       out  1   one-cycle pulse that commits PCNext into the PC register
//  ResultSrc   out  2   00 ALU, 01 PC+1 (link), 10 ReadData
//  PcSrc       out  1   1 = next PC is ImmExt (taken jump/branch)
//  RegWrite    out  1   register file write strobe
//  ImmSrc      out  2   00 R/ALU, 01 mem offset, 10 branch/jump target
//  L           out  1   logical (unsigned) shift select to ALU
//  ALUControl  out  4   ALU operation
//  halted      out  1   1 in HALT state
//  bus_err     out  1   sticky; set on timeout; cleared only by reset
//  illegal     out  1   sticky; set on undefined opcode; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; every output=0; timeout counter=0; any pending req dropped at once.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  Transitions:
//   IDLE->FETCH when run=1.
//   FETCH: imem_req=1 until imem_ack, then ->DECODE.
//   DECODE->EXEC, or ->HALT for 0xF or an undefined opcode.
//   EXEC->MEM for LD/ST; ->WB for all other opcodes.
//   MEM: dmem_req=1 until dmem_ack. LD ->WB. ST ->FETCH with pc_en=1 that cycle, or ->IDLE if run=0.
//   WB->FETCH, or ->IDLE if run=0.
//   HALT is terminal until reset.
//  Opcode map, ALUControl = {0,op[2:0]}:
//   0x0-0x7  ALU ops, ResultSrc=00.
//   0x6      L=1 (logical right shift).
//   0x8 LD   ALU 0000 adds offset, ImmSrc=01, ResultSrc=10.
//   0x9 ST   ALU 0000, ImmSrc=01.
//   0xA JMP  always taken.
//   0xB BEQ  taken if Zero=1.
//   0xC BNE  taken if Zero=0.
//   0xD CALL taken, ResultSrc=01, RegWrite=1.
//   0xE undefined (illegal). 0xF HALT.
//   Branch compares use ALU 0001 (SUB). ImmSrc=10 for opcodes 0xA-0xD.
//  Strobe timing:
//   RegWrite: one cycle, in WB only, for ALU ops, LD and CALL.
//   pc_en: exactly one cycle per instruction, on the last cycle (WB, or MEM+ack for ST).
//   PcSrc: valid only on the pc_en cycle; equals the taken decision latched in EXEC.
//  Hold rules:
//   ALUControl/ImmSrc/L hold from DECODE through instruction end.
//   ResultSrc is valid in WB.
//   All strobes are 0 in IDLE and HALT.
//  Latency: ALU/branch/CALL 4 cycles (FETCH-DECODE-EXEC-WB). LD 5 cycles. ST 4 cycles.
//   Each FETCH/MEM wait cycle adds 1 cycle.
//  Timeout: counter clears on entering FETCH/MEM and increments each cycle req=1 without ack.
//   Reaching MEM_TIMEOUT -> HALT, bus_err=1, req dropped, no pc_en and no RegWrite.
//   An ack in the same cycle the count reaches MEM_TIMEOUT wins: no error.
//  run=0 mid-instruction has no effect; the instruction completes, then ->IDLE.
//  An ack with no req outstanding is ignored.
//  HALT/illegal: no pc_en, so the PC stays at the faulting instruction.
// TESTING
//  T1 reset=0 mid-MEM with dmem_req=1 -> req=0 same cycle; all outputs 0; after release state=IDLE.
//  T2 ADD (0x0), zero-wait acks -> RegWrite=1 and pc_en=1 both in cycle 4 only; ALUControl=0000.
//  T3 LD with dmem_ack after 3 wait cycles -> 8 cycles total; ResultSrc=10 and RegWrite=1 in final cycle.
//  T4 BEQ with Zero=1, then BNE with Zero=1 -> PcSrc=1 on the first pc_en; PcSrc=0 on the second.
//  T5 imem_ack never asserted -> after 16 req cycles: halted=1, bus_err=1, imem_req=0, pc_en never pulses.
//  T6 opcode 0xE -> halted=1, illegal=1, no RegWrite; toggling run has no effect until reset.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake bundle of the multi-cycle sequencer: instruction fetch
// and data access request/acknowledge pairs plus the fetched instruction word.
interface multicycle_ctrl_if;
  logic [18:0] Instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack,
    input  Instr
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack,
    output Instr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 19-bit core: walks FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes and stalls on slow memories with a bus timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     Zero,
  multicycle_ctrl_if.master        mem,
  output logic                     pc_en,
  output logic [1:0]               ResultSrc,
  output logic                     PcSrc,
  output logic                     RegWrite,
  output logic [1:0]               ImmSrc,
  output logic                     L,
  output logic [3:0]               ALUControl,
  output logic                     halted,
  output logic                     bus_err,
  output logic                     illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LINK = 2'b01;
  localparam logic [1:0] RS_MEM  = 2'b10;

  localparam logic [1:0] IMM_R   = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    op_q;
  logic          taken_q;
  logic [TW-1:0] tmo_cnt;

  // Decoded attributes of the latched opcode.
  logic [3:0] dec_alu;
  logic [1:0] dec_imm;
  logic       dec_l;
  logic       dec_wr;
  logic [1:0] dec_rs;
  logic       dec_taken;
  logic       dec_mem;
  logic       dec_st;
  logic       dec_stop;

  logic waiting;
  logic ack_now;
  logic tmo_hit;
  logic active;

  // Only the opcode field steers the sequencer; the rest feeds the datapath.
  logic instr_unused;
  assign instr_unused = ^mem.Instr[18:4];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec_alu   = {1'b0, op_q[2:0]};
    dec_imm   = IMM_R;
    dec_l     = 1'b0;
    dec_wr    = 1'b0;
    dec_rs    = RS_ALU;
    dec_taken = 1'b0;
    dec_mem   = 1'b0;
    dec_st    = 1'b0;
    dec_stop  = 1'b0;
    case (op_q)
      OP_LD: begin
        dec_alu = ALU_ADD;
        dec_imm = IMM_MEM;
        dec_wr  = 1'b1;
        dec_rs  = RS_MEM;
        dec_mem = 1'b1;
      end
      OP_ST: begin
        dec_alu = ALU_ADD;
        dec_imm = IMM_MEM;
        dec_mem = 1'b1;
        dec_st  = 1'b1;
      end
      OP_JMP: begin
        dec_imm   = IMM_BR;
        dec_taken = 1'b1;
      end
      OP_BEQ: begin
        dec_alu   = ALU_SUB;
        dec_imm   = IMM_BR;
        dec_taken = Zero;
      end
      OP_BNE: begin
        dec_alu   = ALU_SUB;
        dec_imm   = IMM_BR;
        dec_taken = ~Zero;
      end
      OP_CALL: begin
        dec_imm   = IMM_BR;
        dec_taken = 1'b1;
        dec_wr    = 1'b1;
        dec_rs    = RS_LINK;
      end
      OP_ILL, OP_HALT: dec_stop = 1'b1;
      default: begin
        dec_wr = 1'b1;
        dec_l  = (op_q == OP_SRL);
      end
    endcase
  end

  // A request cycle without ack on the last permitted count expires the bus;
  // an ack in that same cycle takes priority.
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign ack_now = (state == S_FETCH) ? mem.imem_ack : mem.dmem_ack;
  assign tmo_hit = waiting && !ack_now && (tmo_cnt == TW'(MEM_TIMEOUT - 1));
  assign active  = (state == S_DECODE) || (state == S_EXEC) ||
                   (state == S_MEM)    || (state == S_WB);

  always_comb begin
    state_nxt    = state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    pc_en        = 1'b0;
    PcSrc        = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RS_ALU;
    ImmSrc       = IMM_R;
    L            = 1'b0;
    ALUControl   = 4'b0000;

    if (active) begin
      ALUControl = dec_alu;
      ImmSrc     = dec_imm;
      L          = dec_l;
    end

    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack)  state_nxt = S_DECODE;
        else if (tmo_hit)  state_nxt = S_HALT;
      end
      S_DECODE: begin
        state_nxt = dec_stop ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_nxt = dec_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = dec_st;
        if (mem.dmem_ack) begin
          if (dec_st) begin
            pc_en     = 1'b1;
            PcSrc     = taken_q;
            state_nxt = run ? S_FETCH : S_IDLE;
          end else begin
            state_nxt = S_WB;
          end
        end else if (tmo_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_WB: begin
        pc_en     = 1'b1;
        PcSrc     = taken_q;
        RegWrite  = dec_wr;
        ResultSrc = dec_rs;
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign halted = (state == S_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= 4'h0;
      taken_q <= 1'b0;
      tmo_cnt <= '0;
      bus_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH) && mem.imem_ack) op_q <= mem.Instr[3:0];
      if (state == S_EXEC) taken_q <= dec_taken;
      if (waiting && !ack_now) tmo_cnt <= tmo_cnt + TW'(1);
      else                     tmo_cnt <= '0;
      if (tmo_hit) bus_err <= 1'b1;
      if ((state == S_DECODE) && (op_q == OP_ILL)) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: the bench plays both memories and
// predicts each instruction's timeline and strobes from the opcode rules.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       run   = 1'b0;
  logic       Zero  = 1'b0;
  logic       pc_en;
  logic [1:0] ResultSrc;
  logic       PcSrc;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       L;
  logic [3:0] ALUControl;
  logic       halted;
  logic       bus_err;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .Zero       (Zero),
    .mem        (bus),
    .pc_en      (pc_en),
    .ResultSrc  (ResultSrc),
    .PcSrc      (PcSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .L          (L),
    .ALUControl (ALUControl),
    .halted     (halted),
    .bus_err    (bus_err),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, pc_en, ResultSrc, PcSrc,
            RegWrite, ImmSrc, L, ALUControl, halted, bus_err, illegal};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #1 check("outputs in reset", all_outs(), 18'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Acts as both memories for one instruction; fw/mw are the wait cycles before
  // each ack (negative = never ack). Expectations come from the opcode rules.
  task automatic run_instr(input logic [3:0] op, input logic zero,
                           input int fw, input int mw, input bit drop_run);
    bit ftmo, fault, is_mem, is_st, mtmo, halts, exp_taken, exp_wr, alu_known;
    bit done, started;
    int lat, exp_halt, exp_fcnt, exp_mcnt;
    int cyc, fcnt, mcnt, pce_n, pce_cyc, rw_n, rw_cyc, halt_cyc, we_bad;
    logic [1:0] rs_at, imm_at, exp_rs, exp_imm;
    logic [3:0] alu_at, exp_alu;
    logic       pcsrc_at, l_at;

    is_mem    = (op == 4'h8) || (op == 4'h9);
    is_st     = (op == 4'h9);
    ftmo      = (fw < 0) || (fw >= MEM_TIMEOUT);
    fault     = !ftmo && (op >= 4'hE);
    mtmo      = !ftmo && !fault && is_mem && ((mw < 0) || (mw >= MEM_TIMEOUT));
    halts     = ftmo || fault || mtmo;
    exp_taken = (op == 4'hA) || (op == 4'hD) || (op == 4'hB && zero) || (op == 4'hC && !zero);
    exp_wr    = (op <= 4'h8) || (op == 4'hD);
    exp_rs    = (op == 4'h8) ? 2'b10 : (op == 4'hD) ? 2'b01 : 2'b00;
    exp_imm   = is_mem ? 2'b01 : (op >= 4'hA && op <= 4'hD) ? 2'b10 : 2'b00;
    alu_known = (op <= 4'h9) || (op == 4'hB) || (op == 4'hC);
    exp_alu   = (op <= 4'h7) ? {1'b0, op[2:0]} : is_mem ? 4'b0000 : 4'b0001;
    lat       = 4 + fw + (is_mem ? 1 + mw : 0) - (is_st ? 1 : 0);
    exp_halt  = ftmo ? MEM_TIMEOUT + 1 : fault ? fw + 3 : fw + 4 + MEM_TIMEOUT;
    exp_fcnt  = ftmo ? MEM_TIMEOUT : fw + 1;
    exp_mcnt  = (is_mem && !ftmo && !fault) ? (mtmo ? MEM_TIMEOUT : mw + 1) : 0;

    done = 0; started = 0;
    cyc = 0; fcnt = 0; mcnt = 0; pce_n = 0; pce_cyc = 0; rw_n = 0; rw_cyc = 0;
    halt_cyc = 0; we_bad = 0;
    rs_at = 2'b00; imm_at = 2'b00; alu_at = 4'h0; pcsrc_at = 1'b0; l_at = 1'b0;
    Zero = zero;

    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (bus.imem_req) begin
        started = 1;
        if (fcnt == fw) begin
          bus.imem_ack = 1'b1;
          bus.Instr    = {15'($urandom), op};
        end
        fcnt++;
      end
      if (bus.dmem_req) begin
        if (mcnt == mw) bus.dmem_ack = 1'b1;
        mcnt++;
      end
      #1;
      if (started) begin
        cyc++;
        if (drop_run) run = 1'b0;
        if (bus.dmem_req && (bus.dmem_we !== is_st)) we_bad++;
        if (RegWrite) begin
          rw_n++;
          rw_cyc = cyc;
          rs_at  = ResultSrc;
        end
        if (pc_en) begin
          pce_n++;
          pce_cyc  = cyc;
          pcsrc_at = PcSrc;
          imm_at   = ImmSrc;
          l_at     = L;
          alu_at   = ALUControl;
          done     = 1;
        end
        if (halted) begin
          halt_cyc = cyc;
          done     = 1;
        end
      end
    end

    check($sformatf("op%h finished within budget", op), done, 1);
    check($sformatf("op%h imem_req cycles", op), fcnt, exp_fcnt);
    check($sformatf("op%h dmem_req cycles", op), mcnt, exp_mcnt);
    check($sformatf("op%h dmem_we while req", op), we_bad, 0);
    check($sformatf("op%h pc_en pulses", op), pce_n, halts ? 0 : 1);
    check($sformatf("op%h RegWrite pulses", op), rw_n, (!halts && exp_wr) ? 1 : 0);
    check($sformatf("op%h halted", op), halted, halts);
    check($sformatf("op%h bus_err", op), bus_err, ftmo || mtmo);
    check($sformatf("op%h illegal", op), illegal, fault && (op == 4'hE));
    if (halts) begin
      check($sformatf("op%h halt cycle", op), halt_cyc, exp_halt);
    end else begin
      check($sformatf("op%h latency", op), pce_cyc, lat);
      check($sformatf("op%h PcSrc", op), pcsrc_at, exp_taken);
      check($sformatf("op%h ImmSrc", op), imm_at, exp_imm);
      check($sformatf("op%h L", op), l_at, op == 4'h6);
      if (alu_known) check($sformatf("op%h ALUControl", op), alu_at, exp_alu);
      if (exp_wr) begin
        check($sformatf("op%h RegWrite cycle", op), rw_cyc, lat);
        check($sformatf("op%h ResultSrc", op), rs_at, exp_rs);
      end
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.Instr    = '0;

    #1 check("outputs in initial reset", all_outs(), 18'h0);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;

    // ADD with zero-wait memories, then LD with three data wait cycles.
    run_instr(4'h0, 1'b0, 0, 0, 0);
    run_instr(4'h8, 1'b0, 0, 3, 0);
    // BEQ taken on Zero=1, BNE not taken on Zero=1.
    run_instr(4'hB, 1'b1, 0, 0, 0);
    run_instr(4'hC, 1'b1, 0, 0, 0);
    run_instr(4'h9, 1'b0, 0, 0, 0);
    run_instr(4'hD, 1'b0, 2, 0, 0);
    // Acks arriving on the last permitted wait cycle still succeed.
    run_instr(4'h1, 1'b0, MEM_TIMEOUT - 1, 0, 0);
    run_instr(4'h8, 1'b0, 0, MEM_TIMEOUT - 1, 0);

    for (int i = 0; i < 24; i++) begin
      run_instr(4'($urandom_range(0, 13)), 1'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 4), 0);
    end

    // Dropping run mid-instruction lets it finish, then the core idles.
    run_instr(4'h5, 1'b0, 1, 0, 1);
    repeat (3) @(negedge clk);
    #1 check("idle after run drop", bus.imem_req, 1'b0);
    run = 1'b1;

    // Asynchronous reset in the middle of a data access.
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req;
      bus.dmem_ack = 1'b0;
      bus.Instr    = {15'h1234, 4'h8};
      #1 got = bus.dmem_req;
    end
    check("reached MEM before reset", got, 1'b1);
    bus.imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check("outputs during mid-MEM reset", all_outs(), 18'h0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("IDLE after reset release", bus.imem_req, 1'b0);
    run = 1'b1;
    @(negedge clk);
    #1 check("FETCH after run", bus.imem_req, 1'b1);
    do_reset();

    // Instruction memory never answers.
    run_instr(4'h0, 1'b0, -1, 0, 0);
    @(negedge clk);
    #1 check("imem_req dropped after timeout", bus.imem_req, 1'b0);
    do_reset();

    // Data memory never answers.
    run_instr(4'h8, 1'b0, 0, -1, 0);
    do_reset();

    // Undefined opcode halts; run toggling has no effect.
    run_instr(4'hE, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      run = ~run;
      #1 check("halt holds with run toggling", {halted, bus.imem_req, pc_en, RegWrite}, 4'b1000);
    end
    run = 1'b1;
    do_reset();

    run_instr(4'hF, 1'b0, 1, 0, 0);
    do_reset();

    run_instr(4'h6, 1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
